// File: rtl/logic_pkg.sv
// Shared opcode / function-code constants, FSM encoding and opcode decode
// for the logic-unit issue controller.
package logic_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOT   = 3'b011;
  localparam logic [2:0] OP_LOADI = 3'b100;

  localparam logic [1:0] LU_AND = 2'b00;
  localparam logic [1:0] LU_OR  = 2'b01;
  localparam logic [1:0] LU_XOR = 2'b10;
  localparam logic [1:0] LU_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       loadi;
    logic       not_op;
    logic [1:0] code;
  } dec_t;

  function automatic dec_t decode_op(input logic [2:0] op);
    dec_t d;
    d = '{legal: 1'b1, loadi: 1'b0, not_op: 1'b0, code: LU_AND};
    case (op)
      OP_AND:   d.code = LU_AND;
      OP_OR:    d.code = LU_OR;
      OP_XOR:   d.code = LU_XOR;
      OP_NOT: begin
        d.code   = LU_NOT;
        d.not_op = 1'b1;
      end
      OP_LOADI: d.loadi = 1'b1;
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/logic_regfile.sv
// 4-entry register file: two asynchronous read ports, one synchronous write
// port, synchronous active-low clear of every entry.
module logic_regfile
  import logic_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ra_addr,
  output logic [SIZE-1:0] ra_data,
  input  logic [1:0]      rb_addr,
  output logic [SIZE-1:0] rb_data,
  input  logic            we,
  input  logic [1:0]      wa,
  input  logic [SIZE-1:0] wd
);

  logic [3:0][SIZE-1:0] mem_q;
  logic [3:0][SIZE-1:0] mem_d;

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wa] = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/logic_issue_ctrl.sv
// Issue sequencer for the external 4-function logic unit: accepts an
// instruction, executes it in one cycle against the local register file,
// then holds a result/error response until it is consumed.
module logic_issue_ctrl
  import logic_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_instr,
  input  logic [SIZE-1:0]  in_imm,
  output logic [SIZE-1:0]  lu_x,
  output logic [SIZE-1:0]  lu_y,
  output logic [1:0]       lu_code,
  input  logic [SIZE-1:0]  lu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  state_e            state_q, state_d;
  logic [8:0]        instr_q, instr_d;
  logic [SIZE-1:0]   imm_q, imm_d;
  logic [SIZE-1:0]   res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic [1:0]        rd, rs, rt;
  logic [SIZE-1:0]   rs_data, rt_data;
  logic              rf_we;
  logic [SIZE-1:0]   rf_wd;
  dec_t              dec;

  assign rd  = instr_q[5:4];
  assign rs  = instr_q[3:2];
  assign rt  = instr_q[1:0];
  assign dec = decode_op(instr_q[8:6]);

  logic_regfile #(.SIZE(SIZE)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (rs),
    .ra_data (rs_data),
    .rb_addr (rt),
    .rb_data (rt_data),
    .we      (rf_we),
    .wa      (rd),
    .wd      (rf_wd)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    op_count_d = op_count_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    lu_x       = '0;
    lu_y       = '0;
    lu_code    = LU_AND;
    rf_we      = 1'b0;
    rf_wd      = '0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          instr_d = in_instr;
          imm_d   = in_imm;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Operands are read here and written back at the same edge, so rd may alias rs/rt.
        if (dec.legal) begin
          if (dec.loadi) begin
            rf_wd = imm_q;
          end else begin
            lu_x    = rs_data;
            lu_y    = dec.not_op ? '0 : rt_data;
            lu_code = dec.code;
            rf_wd   = lu_out;
          end
          rf_we      = 1'b1;
          res_data_d = rf_wd;
          res_err_d  = 1'b0;
          op_count_d = (op_count_q == '1) ? op_count_q : op_count_q + CNT_W'(1);
        end else begin
          res_data_d = '0;
          res_err_d  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      op_count_q <= op_count_d;
    end
  end

  // Instruction capture is pure data and only meaningful after an accept.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    imm_q   <= imm_d;
  end

  assign out_data = res_data_q;
  assign out_err  = res_err_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_logic_issue_ctrl.sv
// Directed bench for logic_issue_ctrl with a behavioural logic unit attached.
module tb_logic_issue_ctrl;

  localparam int SIZE  = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [8:0]       in_instr;
  logic [SIZE-1:0]  in_imm;
  logic [SIZE-1:0]  lu_x;
  logic [SIZE-1:0]  lu_y;
  logic [1:0]       lu_code;
  logic [SIZE-1:0]  lu_out;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_data;
  logic             out_err;
  logic [CNT_W-1:0] op_count;

  int total;
  int bad;

  logic_issue_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_imm    (in_imm),
    .lu_x      (lu_x),
    .lu_y      (lu_y),
    .lu_code   (lu_code),
    .lu_out    (lu_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .op_count  (op_count)
  );

  always_comb begin
    lu_out = '0;
    case (lu_code)
      2'b00: lu_out = lu_x & lu_y;
      2'b01: lu_out = lu_x | lu_y;
      2'b10: lu_out = lu_x ^ lu_y;
      2'b11: lu_out = ~lu_x;
      default: lu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive at a negedge, accept on the next posedge, EXEC for one cycle,
  // then the response is visible two edges after the accept cycle began.
  task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [1:0] rt, input logic [7:0] imm,
                       input bit chk_lu, input logic [7:0] ex_x, input logic [7:0] ex_y,
                       input logic [1:0] ex_code, input logic [7:0] ex_data,
                       input logic ex_err, input logic [15:0] ex_cnt);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = {op, rd, rs, rt};
    in_imm   = imm;
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = '0;
    in_imm   = '0;
    chk({tag, ".exec_out_valid"}, 32'(out_valid), 32'd0);
    if (chk_lu) begin
      chk({tag, ".lu_x"}, 32'(lu_x), 32'(ex_x));
      chk({tag, ".lu_y"}, 32'(lu_y), 32'(ex_y));
      chk({tag, ".lu_code"}, 32'(lu_code), 32'(ex_code));
    end
    @(negedge clk);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_data"}, 32'(out_data), 32'(ex_data));
    chk({tag, ".out_err"}, 32'(out_err), 32'(ex_err));
    chk({tag, ".op_count"}, 32'(op_count), 32'(ex_cnt));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_imm    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.op_count", 32'(op_count), 32'd0);
    chk("rst.lu_code", 32'(lu_code), 32'd0);

    // Fill the register file
    issue("ldi_r0", 3'b100, 2'd0, 2'd0, 2'd0, 8'hF0, 1'b0, 8'h00, 8'h00, 2'b00, 8'hF0, 1'b0, 16'd1);
    issue("ldi_r1", 3'b100, 2'd1, 2'd0, 2'd0, 8'h3C, 1'b0, 8'h00, 8'h00, 2'b00, 8'h3C, 1'b0, 16'd2);
    issue("ldi_r2", 3'b100, 2'd2, 2'd0, 2'd0, 8'hAA, 1'b0, 8'h00, 8'h00, 2'b00, 8'hAA, 1'b0, 16'd3);
    issue("ldi_r3", 3'b100, 2'd3, 2'd0, 2'd0, 8'h55, 1'b0, 8'h00, 8'h00, 2'b00, 8'h55, 1'b0, 16'd4);

    // Logic operations
    issue("and_r0r1", 3'b000, 2'd3, 2'd0, 2'd1, 8'h00, 1'b1, 8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0, 16'd5);
    issue("rd_r3",    3'b001, 2'd3, 2'd3, 2'd3, 8'h00, 1'b1, 8'h30, 8'h30, 2'b01, 8'h30, 1'b0, 16'd6);
    issue("ldi_r3b",  3'b100, 2'd3, 2'd0, 2'd0, 8'h55, 1'b0, 8'h00, 8'h00, 2'b00, 8'h55, 1'b0, 16'd7);
    issue("or_r1r2",  3'b001, 2'd1, 2'd1, 2'd2, 8'h00, 1'b1, 8'h3C, 8'hAA, 2'b01, 8'hBE, 1'b0, 16'd8);
    issue("xor_r2r3", 3'b010, 2'd2, 2'd2, 2'd3, 8'h00, 1'b1, 8'hAA, 8'h55, 2'b10, 8'hFF, 1'b0, 16'd9);
    issue("not_r0",   3'b011, 2'd0, 2'd0, 2'd2, 8'h00, 1'b1, 8'hF0, 8'h00, 2'b11, 8'h0F, 1'b0, 16'd10);

    // Illegal opcode leaves state untouched
    issue("illegal",  3'b110, 2'd0, 2'd1, 2'd2, 8'h77, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1, 16'd10);
    issue("rd_r0",    3'b001, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 8'h0F, 8'h0F, 2'b01, 8'h0F, 1'b0, 16'd11);

    // Backpressure: response held, new instruction refused
    in_valid = 1'b1;
    in_instr = {3'b000, 2'd1, 2'd1, 2'd2};
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {3'b100, 2'd0, 2'd0, 2'd0};
    in_imm   = 8'h77;
    for (int i = 0; i < 10; i++) begin
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.out_data", 32'(out_data), 32'hBE);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_instr  = '0;
    in_imm    = '0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.released", 32'(out_valid), 32'd0);
    chk("bp.op_count", 32'(op_count), 32'd12);
    issue("bp_rd_r0", 3'b001, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 8'h0F, 8'h0F, 2'b01, 8'h0F, 1'b0, 16'd13);

    // Reset during EXEC
    in_valid = 1'b1;
    in_instr = {3'b100, 2'd0, 2'd0, 2'd0};
    in_imm   = 8'h99;
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = '0;
    in_imm   = '0;
    chk("mrst.exec", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.in_ready", 32'(in_ready), 32'd1);
    chk("mrst.op_count", 32'(op_count), 32'd0);
    chk("mrst.out_data", 32'(out_data), 32'd0);
    issue("mrst_rd_r0", 3'b001, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0, 16'd1);

    // Counter saturation
    force dut.op_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk);
    chk("sat.preload", 32'(op_count), 32'hFFFE);
    issue("sat_ldi", 3'b100, 2'd1, 2'd0, 2'd0, 8'h11, 1'b0, 8'h00, 8'h00, 2'b00, 8'h11, 1'b0, 16'hFFFF);
    issue("sat_xor", 3'b010, 2'd2, 2'd1, 2'd1, 8'h00, 1'b1, 8'h11, 8'h11, 2'b10, 8'h00, 1'b0, 16'hFFFF);
    issue("sat_not", 3'b011, 2'd3, 2'd1, 2'd0, 8'h00, 1'b1, 8'h11, 8'h00, 2'b11, 8'hEE, 1'b0, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
